// File: rtl/ped_pkg.sv
// ----------------------------------------------------------------------------
// ped_pkg
// Shared types and constants for the pedestrian crossing signal block.
//   ped_state_e   : per-crossing FSM state (IDLE, WAIT, WALK, CLEAR)
//   CNT_W_DEF     : default width of the controller countdown
//   RST_WALK / RST_DONT_WALK : lamp values driven while in reset or fault
//   lamp_ok()     : true when exactly one of a road's three lamps is lit
// ----------------------------------------------------------------------------
package ped_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      WALK  = 2'd2,
      CLEAR = 2'd3
   } ped_state_e;

   localparam int   CNT_W_DEF     = 7;
   localparam logic RST_WALK      = 1'b0;
   localparam logic RST_DONT_WALK = 1'b1;

   // Exactly-one-hot check over three lamps: odd parity rules out 0 and 2
   // lit, the AND term rules out all three lit.
   function automatic logic lamp_ok(input logic r, input logic y, input logic g);
      return (r ^ y ^ g) & ~(r & y & g);
   endfunction

endpackage

// File: rtl/ped_crossing_fsm.sv
// ----------------------------------------------------------------------------
// ped_crossing_fsm
// One pedestrian crossing: button synchroniser + debounce, request FSM,
// WALK / flashing DON'T WALK generation and pedestrian countdown.
// "x" is the road this crossing spans, "y" is the other road.
// Optional feature macro: PED_AUDIO_EN (adds tick_o).
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   btn_raw_i          raw asynchronous push-button
//   block_i            fault: hold in IDLE, DON'T WALK solid, no requests
//   red_x_i            red lamp of road x
//   red_y_i, yellow_y_i, green_y_i   lamps of road y
//   countdown_i        controller remaining time
//   ped_button_o       one-cycle request pulse to the controller
//   walk_o, dont_walk_o, waiting_o   pedestrian head and request indicator
//   ped_countdown_o    seconds left to cross (0 outside WALK/CLEAR)
//   tick_o             audio tick (only with PED_AUDIO_EN)
// ----------------------------------------------------------------------------
module ped_crossing_fsm
   import ped_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 2,
   parameter int CLEAR_TIME      = 10,
   parameter int FLASH_DIV       = 1,
   parameter int CNT_W           = CNT_W_DEF
)(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             btn_raw_i,
   input  logic             block_i,
   input  logic             red_x_i,
   input  logic             red_y_i,
   input  logic             yellow_y_i,
   input  logic             green_y_i,
   input  logic [CNT_W-1:0] countdown_i,
   output logic             ped_button_o,
   output logic             walk_o,
   output logic             dont_walk_o,
   output logic             waiting_o,
   output logic [CNT_W-1:0] ped_countdown_o
`ifdef PED_AUDIO_EN
   ,
   output logic             tick_o
`endif
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int FW = $clog2(2 * FLASH_DIV + 1);
   localparam logic [DW-1:0]    DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [FW-1:0]    FLASH_HALF = FW'(FLASH_DIV);
   localparam logic [FW-1:0]    FLASH_LAST = FW'(2 * FLASH_DIV - 1);
   localparam logic [CNT_W-1:0] CLR_T      = CNT_W'(CLEAR_TIME);

   logic [1:0]       sync_q;
   logic             db_q;
   logic [DW-1:0]    db_cnt_q;
   ped_state_e       state_q;
   logic             pending_q;
   logic [FW-1:0]    clr_cnt_q;
   logic             ped_button_q;
   logic             walk_q;
   logic             dont_walk_q;
   logic             waiting_q;
   logic [CNT_W-1:0] pcnt_q;

   logic             press_s;
   logic             win_s;
   logic             end_walk_s;
   logic [CNT_W-1:0] walk_cnt_s;
   logic [FW-1:0]    clr_nxt_s;

   // Two-flop synchroniser followed by a stability counter on the accepted level.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q   <= 2'b00;
         db_q     <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         sync_q <= {sync_q[0], btn_raw_i};
         if (sync_q[1] != db_q) begin
            if (db_cnt_q == DB_LAST) begin
               db_q     <= sync_q[1];
               db_cnt_q <= '0;
            end else begin
               db_cnt_q <= db_cnt_q + DW'(1);
            end
         end else begin
            db_cnt_q <= '0;
         end
      end
   end

   // Press fires on the edge where a rising level is accepted, so the FSM
   // registers its pulse on that same edge (2 + DEBOUNCE_CYCLES latency).
   always_comb begin
      press_s    = sync_q[1] & ~db_q & (db_cnt_q == DB_LAST);
      win_s      = red_x_i & green_y_i & (countdown_i > CLR_T);
      end_walk_s = (countdown_i <= CLR_T) | yellow_y_i;
      if (countdown_i > CLR_T) begin
         walk_cnt_s = countdown_i - CLR_T;
      end else begin
         walk_cnt_s = '0;
      end
      if (clr_cnt_q == FLASH_LAST) begin
         clr_nxt_s = '0;
      end else begin
         clr_nxt_s = clr_cnt_q + FW'(1);
      end
   end

   // Request FSM with registered lamp, request and countdown outputs.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || block_i) begin
         state_q      <= IDLE;
         pending_q    <= 1'b0;
         clr_cnt_q    <= '0;
         ped_button_q <= 1'b0;
         walk_q       <= RST_WALK;
         dont_walk_q  <= RST_DONT_WALK;
         waiting_q    <= 1'b0;
         pcnt_q       <= '0;
      end else begin
         ped_button_q <= 1'b0;
         case (state_q)
            IDLE: begin
               walk_q      <= 1'b0;
               dont_walk_q <= 1'b1;
               pcnt_q      <= '0;
               if (press_s) begin
                  state_q      <= WAIT;
                  waiting_q    <= 1'b1;
                  ped_button_q <= 1'b1;
               end else begin
                  waiting_q <= 1'b0;
               end
            end
            WAIT: begin
               if (win_s) begin
                  state_q     <= WALK;
                  walk_q      <= 1'b1;
                  dont_walk_q <= 1'b0;
                  waiting_q   <= 1'b0;
                  pcnt_q      <= walk_cnt_s;
               end else begin
                  walk_q      <= 1'b0;
                  dont_walk_q <= 1'b1;
                  waiting_q   <= 1'b1;
                  pcnt_q      <= '0;
               end
            end
            WALK: begin
               pending_q <= 1'b0;
               if (end_walk_s) begin
                  state_q     <= CLEAR;
                  walk_q      <= 1'b0;
                  dont_walk_q <= 1'b1;
                  clr_cnt_q   <= '0;
                  pcnt_q      <= countdown_i;
               end else begin
                  walk_q      <= 1'b1;
                  dont_walk_q <= 1'b0;
                  pcnt_q      <= walk_cnt_s;
               end
            end
            CLEAR: begin
               walk_q <= 1'b0;
               if (red_y_i) begin
                  dont_walk_q <= 1'b1;
                  pcnt_q      <= '0;
                  clr_cnt_q   <= '0;
                  pending_q   <= 1'b0;
                  // A request latched during CLEAR is issued as the head goes solid.
                  if (pending_q || press_s) begin
                     state_q      <= WAIT;
                     waiting_q    <= 1'b1;
                     ped_button_q <= 1'b1;
                  end else begin
                     state_q   <= IDLE;
                     waiting_q <= 1'b0;
                  end
               end else begin
                  clr_cnt_q   <= clr_nxt_s;
                  dont_walk_q <= (clr_nxt_s < FLASH_HALF);
                  pcnt_q      <= countdown_i;
                  if (press_s) begin
                     pending_q <= 1'b1;
                     waiting_q <= 1'b1;
                  end else begin
                     pending_q <= pending_q;
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               walk_q      <= 1'b0;
               dont_walk_q <= 1'b1;
               waiting_q   <= 1'b0;
               pcnt_q      <= '0;
            end
         endcase
      end
   end

`ifdef PED_AUDIO_EN
   logic tick_q;

   // Audio tick: every cycle of WALK, once per flash period in CLEAR.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || block_i) begin
         tick_q <= 1'b0;
      end else begin
         case (state_q)
            WAIT:    tick_q <= win_s;
            WALK:    tick_q <= 1'b1;
            CLEAR:   tick_q <= ~red_y_i & (clr_nxt_s == '0);
            default: tick_q <= 1'b0;
         endcase
      end
   end

   assign tick_o = tick_q;
`endif

   assign ped_button_o    = ped_button_q;
   assign walk_o          = walk_q;
   assign dont_walk_o     = dont_walk_q;
   assign waiting_o       = waiting_q;
   assign ped_countdown_o = pcnt_q;

endmodule

// File: rtl/ped_crossing_signal.sv
// ----------------------------------------------------------------------------
// ped_crossing_signal
// Pedestrian-side companion to the traffic light controller for crossing A
// (spans road A) and crossing B (spans road B). Detects illegal lamp
// combinations and cross-wires the controller lamps into two crossing FSMs.
// Optional feature macro: PED_AUDIO_EN (adds tick_A, tick_B).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   btn_raw_A/B                raw push-buttons
//   red/yellow/green_A/B       controller lamps per road
//   countdown                  controller remaining time
//   ped_button_A/B             one-cycle request pulses to the controller
//   walk_A/B, dont_walk_A/B    pedestrian heads
//   waiting_A/B                request registered indicators
//   ped_countdown_A/B          seconds left to cross
//   fault                      sticky illegal-lamp flag
//   tick_A/B                   audio ticks (only with PED_AUDIO_EN)
// ----------------------------------------------------------------------------
module ped_crossing_signal
   import ped_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 2,
   parameter int CLEAR_TIME      = 10,
   parameter int FLASH_DIV       = 1,
   parameter int CNT_W           = CNT_W_DEF
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_raw_A,
   input  logic             btn_raw_B,
   input  logic             red_A,
   input  logic             yellow_A,
   input  logic             green_A,
   input  logic             red_B,
   input  logic             yellow_B,
   input  logic             green_B,
   input  logic [CNT_W-1:0] countdown,
   output logic             ped_button_A,
   output logic             ped_button_B,
   output logic             walk_A,
   output logic             walk_B,
   output logic             dont_walk_A,
   output logic             dont_walk_B,
   output logic             waiting_A,
   output logic             waiting_B,
   output logic [CNT_W-1:0] ped_countdown_A,
   output logic [CNT_W-1:0] ped_countdown_B,
   output logic             fault
`ifdef PED_AUDIO_EN
   ,
   output logic             tick_A,
   output logic             tick_B
`endif
);

   logic fault_q;
   logic fault_now_s;
   logic block_s;

   // Illegal lamp combination this cycle; the FSMs are blocked on the same
   // edge that sets the sticky flag.
   always_comb begin
      fault_now_s = ~lamp_ok(red_A, yellow_A, green_A)
                  | ~lamp_ok(red_B, yellow_B, green_B)
                  | (green_A & green_B);
      block_s     = fault_now_s | fault_q;
   end

   // Sticky fault flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_q | fault_now_s;
      end
   end

   assign fault = fault_q;

   ped_crossing_fsm #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CLEAR_TIME      (CLEAR_TIME),
      .FLASH_DIV       (FLASH_DIV),
      .CNT_W           (CNT_W)
   ) u_cross_a (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .btn_raw_i       (btn_raw_A),
      .block_i         (block_s),
      .red_x_i         (red_A),
      .red_y_i         (red_B),
      .yellow_y_i      (yellow_B),
      .green_y_i       (green_B),
      .countdown_i     (countdown),
      .ped_button_o    (ped_button_A),
      .walk_o          (walk_A),
      .dont_walk_o     (dont_walk_A),
      .waiting_o       (waiting_A),
      .ped_countdown_o (ped_countdown_A)
`ifdef PED_AUDIO_EN
      ,
      .tick_o          (tick_A)
`endif
   );

   ped_crossing_fsm #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CLEAR_TIME      (CLEAR_TIME),
      .FLASH_DIV       (FLASH_DIV),
      .CNT_W           (CNT_W)
   ) u_cross_b (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .btn_raw_i       (btn_raw_B),
      .block_i         (block_s),
      .red_x_i         (red_B),
      .red_y_i         (red_A),
      .yellow_y_i      (yellow_A),
      .green_y_i       (green_A),
      .countdown_i     (countdown),
      .ped_button_o    (ped_button_B),
      .walk_o          (walk_B),
      .dont_walk_o     (dont_walk_B),
      .waiting_o       (waiting_B),
      .ped_countdown_o (ped_countdown_B)
`ifdef PED_AUDIO_EN
      ,
      .tick_o          (tick_B)
`endif
   );

endmodule

// File: doc/ped_crossing_signal.md
Name: ped_crossing_signal

Overview:
- Pedestrian-side companion to traffic_light_system for two crossings: crossing A spans road A, crossing B spans road B.
- Conditions the raw push-buttons and issues one-cycle ped_button_A/B request pulses to the controller.
- Watches the controller's lamp outputs and countdown to drive WALK / DON'T WALK heads.
- Sits between the pedestrian poles and the controller.

Parameters:
- DEBOUNCE_CYCLES, 2: cycles a synchronised button level must stay stable before it is accepted.
- CLEAR_TIME, 10: countdown value at or below which WALK ends and flashing DON'T WALK begins.
- FLASH_DIV, 1: cycles per flash half-period in CLEAR.
- CNT_W, 7: countdown width.

Ports:
- clk  in  1  system clock (1 s tick).
- rst_n  in  1  reset; synchronous, active-low.
- btn_raw_A  in  1  raw asynchronous button, crossing A.
- btn_raw_B  in  1  raw asynchronous button, crossing B.
- red_A, yellow_A, green_A  in  1 each  road A lamps from controller.
- red_B, yellow_B, green_B  in  1 each  road B lamps from controller.
- countdown  in  CNT_W  controller remaining-time value.
- ped_button_A  out  1  one-cycle request pulse to controller.
- ped_button_B  out  1  one-cycle request pulse to controller.
- walk_A, walk_B  out  1  WALK lamp.
- dont_walk_A, dont_walk_B  out  1  DON'T WALK lamp (solid or flashing).
- waiting_A, waiting_B  out  1  "request registered" indicator.
- ped_countdown_A, ped_countdown_B  out  CNT_W  seconds left to cross; 0 outside WALK/CLEAR.
- fault  out  1  illegal lamp combination seen.

Behaviour:
- Reset (rst_n==0 at a clk edge):
  - walk=0, dont_walk=1, waiting=0, ped_button=0, ped_countdown=0, fault=0.
  - Synchroniser and debounce state cleared; both FSMs go to IDLE.
  - Reset asserted mid-WALK forces DON'T WALK solid on the next edge.
- Button path per crossing:
  - 2-flop synchroniser, then debounce counter; accepted level changes only after DEBOUNCE_CYCLES stable cycles.
  - Accepted rising edge is a "press". Latency from raw edge to press is 2+DEBOUNCE_CYCLES cycles.
- Crossing X, other road Y. Walk legality requires red_X && green_Y.
- FSM per crossing, states IDLE, WAIT, WALK, CLEAR:
  - IDLE: press -> WAIT, waiting=1, ped_button_X=1 for exactly one cycle.
  - WAIT: enter WALK when red_X && green_Y && countdown>CLEAR_TIME. Presses in WAIT produce no extra pulse.
  - WALK: walk=1, dont_walk=0, ped_countdown=countdown-CLEAR_TIME. Go to CLEAR when countdown<=CLEAR_TIME or yellow_Y. Presses in WALK are ignored.
  - CLEAR: walk=0; dont_walk toggles every FLASH_DIV cycles, starting on; ped_countdown=countdown. Go to IDLE on red_Y, with dont_walk solid. A press in CLEAR latches a pending request: on IDLE entry, go straight to WAIT and emit the pulse then.
- Entering WAIT while already in a legal window with countdown<=CLEAR_TIME does not walk; the FSM waits for the next window.
- Both crossings pressed in the same cycle: both pulse in that cycle, independently.
- Fault:
  - Trigger: any road with not exactly one lamp lit, or green_A&&green_B.
  - Response: fault=1 (sticky until reset); both FSMs forced to IDLE with dont_walk solid; no further request pulses.
- ped_countdown saturates at 0; no underflow.

Optional Feature:
- PED_AUDIO_EN defined: adds outputs tick_A, tick_B.
  - tick=1 for one cycle every cycle in WALK.
  - tick=1 every 2*FLASH_DIV cycles in CLEAR.
  - tick=0 otherwise and in reset.
- Undefined: the ports and logic are absent.

Decomposition:
- Package ped_pkg: state enum {IDLE, WAIT, WALK, CLEAR} (2 bits), CNT_W default, reset lamp constants.
- Sub-module ped_crossing_fsm (debounce, FSM, flash, countdown), instantiated twice.
- Top contains fault detection and the cross-wiring of lamps.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> dont_walk_A/B=1, walk=0, ped_button=0, fault=0.
- btn_raw_B held 4 cycles while road A green -> exactly one ped_button_B pulse, 4 cycles after the raw edge.
  - waiting_B=1.
  - When green_A and countdown=60: walk_B=1, ped_countdown_B=50.
- WALK_B with countdown reaching 10 -> walk_B=0, dont_walk_B toggles each cycle.
  - On red_A: dont_walk_B solid, waiting_B=0.
- btn_raw_A pressed 5 times, 4 cycles on / 4 off, while in WAIT -> only one ped_button_A pulse total.
- Press during CLEAR_A -> no pulse in CLEAR; one pulse on the cycle IDLE is re-entered; FSM goes to WAIT.
- Force green_A=green_B=1 for 1 cycle -> fault=1 next cycle, both dont_walk solid, fault held until rst_n=0.
